axi_read_arbiter: RTL and testbench
===================================

# axi_read_arbiter

Two-master to one-slave AXI read arbiter for the read-side interconnect. It takes AR requests from two read masters, grants one at a time with round-robin priority, and forwards the winning request to a single slave AR port. It records the grant order in an in-order tracking FIFO and steers each returning R burst back to the master that issued it. It sits between two read-master instances and the shared slave.

## Interface
Parameters:
- BusWidth, 32, address/data width
- tagbits, 1, ARID/RID width
- MAX_OUTSTANDING, 4, depth of grant-order FIFO; power of two, ≥2

Ports (x ∈ {0,1}):
- ACLK  in  1  clock; all state changes on rising edge
- ARESET  in  1  asynchronous, active-high reset
- Mx_ARVALID  in  1  master x request valid
- Mx_ARREADY  out  1  master x request accepted
- Mx_ARID / Mx_ARADDR / Mx_ARLEN / Mx_ARSIZE / Mx_ARBURST  in  tagbits/BusWidth/4/2/2  master x request fields
- S_ARVALID  out  1  slave request valid
- S_ARREADY  in  1  slave accepts request
- S_ARID / S_ARADDR / S_ARLEN / S_ARSIZE / S_ARBURST  out  tagbits/BusWidth/4/2/2  registered request to slave
- S_RID / S_RDATA / S_RRESP / S_RLAST / S_RVALID  in  tagbits/BusWidth/2/1/1  slave read data
- S_RREADY  out  1  arbiter ready for slave R beat
- Mx_RID / Mx_RDATA / Mx_RRESP / Mx_RLAST  out  tagbits/BusWidth/2/1  S_R* fields broadcast to both masters
- Mx_RVALID  in→out  1  out; R beat valid for master x
- Mx_RREADY  in  1  master x accepts R beat
- rid_err  out  1  sticky RID-mismatch flag (see Configuration)

## Operation
- AR FSM states:
  - IDLE: accept a new request.
  - SEND: present the latched request to the slave.
- rr: 1-bit round-robin pointer; reset value 0.
- Grant in IDLE:
  - Applies only when the FIFO is not full.
  - Both masters requesting: master rr wins.
  - One master requesting: that master wins.
  - Mx_ARREADY = IDLE && not full && x is the winner. This is combinational and at most one is high.
- On the Mx_ARVALID & Mx_ARREADY edge:
  - Latch Mx_AR* into S_AR*.
  - Latch winner index into gidx.
  - Go to SEND.
- SEND:
  - S_ARVALID=1; S_AR* held stable.
  - On S_ARREADY edge: push {gidx, S_ARID} into the FIFO, set rr = ~gidx, then return to IDLE.
- Tracking FIFO:
  - MAX_OUTSTANDING entries.
  - Wrapping read/write pointers plus a count of width clog2(MAX_OUTSTANDING)+1.
  - full = (count==MAX_OUTSTANDING); empty = (count==0).
- R steering (combinational off FIFO head):
  - Mx_RVALID = S_RVALID && !empty && head.idx==x.
  - S_RREADY = !empty && Mx_RREADY[head.idx].
- Pop the FIFO on an S_RVALID & S_RREADY & S_RLAST edge.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Empty FIFO: S_RREADY=0 and no Mx_RVALID. Stray beats are stalled, never dropped.

## Timing
- Reset values:
  - State IDLE, rr=0, FIFO empty.
  - S_ARVALID=0, all S_AR* =0, rid_err=0.
  - Mx_ARREADY and Mx_RVALID low (FIFO empty).
- Reset asserted mid-burst: all state returns immediately to the reset values. In-flight bursts are forgotten.
- AR latency: Mx handshake in cycle N gives S_ARVALID high in cycle N+1. Minimum turnaround is 2 cycles per request (IDLE→SEND→IDLE).
- S_ARVALID never drops before S_ARREADY (AXI rule). Latched fields do not change during SEND.
- R path adds zero cycles: a beat accepted in cycle N by master x is a slave handshake in cycle N.
- Grants are refused while full. The cycle a pop frees a slot, the grant is still blocked; it proceeds the next cycle (count is registered).

## Configuration
- Macro: ARB_RID_CHECK_EN.
- Defined:
  - On every accepted R beat, compare S_RID with head.id.
  - On a mismatch, set rid_err (sticky until reset). The beat is still forwarded.
- Undefined:
  - The ID field is not stored in the FIFO (entry is the 1-bit index only).
  - rid_err is tied to 0.

## Test plan
- Single request: M0 ARADDR=0x100, ARLEN=3, S_ARREADY=1 → S_ARVALID in the next cycle with ADDR 0x100. Four R beats reach M0 only. FIFO empty after the RLAST beat.
- Contention: M0 and M1 both valid from reset → grant order M0, M1, M0, M1 over 4 requests; rr alternates.
- Backpressure: S_ARREADY low for 5 cycles → S_ARVALID and S_AR* stable for 5 cycles. Neither Mx_ARREADY is asserted.
- Full: 4 grants with no R traffic → the 5th request is held (Mx_ARREADY=0). After the first RLAST pop, it is granted one cycle later.
- R stall and ordering:
  - M1 burst queued behind an M0 burst; M0_RREADY=0 → S_RREADY=0 and M1 sees no RVALID.
  - Release M0_RREADY → M0 receives its beats, then M1.
- With ARB_RID_CHECK_EN: return RID=1 for an ARID=0 burst → rid_err=1 after the first beat; it stays 1 until ARESET.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// AXI read-channel bundle (AR + R) shared by the arbiter's master-side and slave-side ports.
// The master modport is the view of whoever issues AR requests and consumes R beats.
interface axi_read_arbiter_if #(
  parameter int BusWidth = 32,
  parameter int tagbits  = 1
);
  logic                arvalid;
  logic                arready;
  logic [tagbits-1:0]  arid;
  logic [BusWidth-1:0] araddr;
  logic [3:0]          arlen;
  logic [1:0]          arsize;
  logic [1:0]          arburst;
  logic [tagbits-1:0]  rid;
  logic [BusWidth-1:0] rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-master round-robin AXI read arbiter; a grant-order FIFO steers R bursts back in order.
// Optional feature macro ARB_RID_CHECK_EN: store ARID per grant and raise sticky rid_err on RID mismatch.
module axi_read_arbiter #(
  parameter int BusWidth        = 32,
  parameter int tagbits         = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               ACLK,
  input  logic               ARESET,
  axi_read_arbiter_if.slave  m0,
  axi_read_arbiter_if.slave  m1,
  axi_read_arbiter_if.master s,
  output logic               rid_err
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_nxt;
  logic                rr, gidx, win, accept, push, pop, full, empty;
  logic [tagbits-1:0]  arid_q;
  logic [BusWidth-1:0] araddr_q;
  logic [3:0]          arlen_q;
  logic [1:0]          arsize_q, arburst_q;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                fifo_idx [MAX_OUTSTANDING];
  logic                head_idx;

  // Round-robin pointer only matters when both masters contend.
  assign win    = (m0.arvalid && m1.arvalid) ? rr : m1.arvalid;
  assign accept = m0.arready || m1.arready;
  assign push   = (state == SEND) && s.arready;
  assign pop    = s.rvalid && s.rready && s.rlast;
  assign full   = (count == CW'(MAX_OUTSTANDING));
  assign empty  = (count == '0);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    s.arvalid  = 1'b0;
    case (state)
      IDLE: begin
        if (!full) begin
          m0.arready = m0.arvalid && !win;
          m1.arready = m1.arvalid && win;
          if (m0.arvalid || m1.arvalid) state_nxt = SEND;
        end
      end
      SEND: begin
        s.arvalid = 1'b1;
        if (s.arready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // AR capture: fields stay frozen for the whole SEND phase.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      gidx      <= 1'b0;
      rr        <= 1'b0;
    end else begin
      if (accept) begin
        gidx      <= win;
        arid_q    <= win ? m1.arid    : m0.arid;
        araddr_q  <= win ? m1.araddr  : m0.araddr;
        arlen_q   <= win ? m1.arlen   : m0.arlen;
        arsize_q  <= win ? m1.arsize  : m0.arsize;
        arburst_q <= win ? m1.arburst : m0.arburst;
      end
      if (push) rr <= ~gidx;
    end
  end

  assign s.arid    = arid_q;
  assign s.araddr  = araddr_q;
  assign s.arlen   = arlen_q;
  assign s.arsize  = arsize_q;
  assign s.arburst = arburst_q;

  // Grant-order FIFO: pointers wrap naturally because depth is a power of two.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) fifo_idx[wr_ptr] <= gidx;
  end

  assign head_idx = fifo_idx[rd_ptr];

  // R steering is purely combinational off the FIFO head; an empty FIFO stalls stray beats.
  assign m0.rvalid = s.rvalid && !empty && !head_idx;
  assign m1.rvalid = s.rvalid && !empty && head_idx;
  assign s.rready  = !empty && (head_idx ? m1.rready : m0.rready);

  assign m0.rid   = s.rid;
  assign m0.rdata = s.rdata;
  assign m0.rresp = s.rresp;
  assign m0.rlast = s.rlast;
  assign m1.rid   = s.rid;
  assign m1.rdata = s.rdata;
  assign m1.rresp = s.rresp;
  assign m1.rlast = s.rlast;

`ifdef ARB_RID_CHECK_EN
  logic [tagbits-1:0] fifo_id [MAX_OUTSTANDING];

  always_ff @(posedge ACLK) begin
    if (push) fifo_id[wr_ptr] <= arid_q;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rid_err <= 1'b0;
    else if (s.rvalid && s.rready && (s.rid != fifo_id[rd_ptr])) rid_err <= 1'b1;
  end
`else
  assign rid_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: grant table, AR/R scoreboards and multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_axi_read_arbiter;

  logic ACLK = 1'b0;
  logic ARESET;
  logic rid_err;

  always #5 ACLK = ~ACLK;

  axi_read_arbiter_if #(.BusWidth(32), .tagbits(1)) m0_if ();
  axi_read_arbiter_if #(.BusWidth(32), .tagbits(1)) m1_if ();
  axi_read_arbiter_if #(.BusWidth(32), .tagbits(1)) s_if ();

  axi_read_arbiter #(.BusWidth(32), .tagbits(1), .MAX_OUTSTANDING(4)) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .rid_err (rid_err)
  );

`ifdef ARB_RID_CHECK_EN
  localparam logic RID_CHK = 1'b1;
`else
  localparam logic RID_CHK = 1'b0;
`endif

  typedef struct {logic [31:0] addr; logic id; logic [3:0] len;} areq_t;
  typedef struct {logic [31:0] data; logic id; logic last;} rbeat_t;
  typedef struct {logic mst; logic [31:0] data;} rexp_t;
  typedef struct {logic m0v; logic m1v; logic e0; logic e1;} gvec_t;

  areq_t  mreq0[$], mreq1[$], ar_q[$];
  rbeat_t sbeat_q[$];
  rexp_t  r_q[$];
  int     checks = 0;
  int     errors = 0;
  logic   pop_seen, ar0_at_pop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    m0_if.arvalid = (mreq0.size() != 0);
    if (mreq0.size() != 0) begin
      m0_if.araddr = mreq0[0].addr; m0_if.arid = mreq0[0].id; m0_if.arlen = mreq0[0].len;
    end
    m1_if.arvalid = (mreq1.size() != 0);
    if (mreq1.size() != 0) begin
      m1_if.araddr = mreq1[0].addr; m1_if.arid = mreq1[0].id; m1_if.arlen = mreq1[0].len;
    end
    s_if.rvalid = (sbeat_q.size() != 0);
    if (sbeat_q.size() != 0) begin
      s_if.rdata = sbeat_q[0].data; s_if.rid = sbeat_q[0].id; s_if.rlast = sbeat_q[0].last;
    end
  endtask

  task automatic check_r(input logic mst, input logic [31:0] data);
    rexp_t e;
    if (r_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL r_unexpected: got beat %0h at master %0d, required none", data, mst);
    end else begin
      e = r_q.pop_front();
      chk("r_master", mst, e.mst);
      chk("r_data", data, e.data);
    end
  endtask

  // One clock: observe at the falling edge, update stimulus just after the rising edge.
  task automatic tick();
    logic h0, h1, hr, hs;
    areq_t e;
    @(negedge ACLK);
    h0 = m0_if.arvalid && m0_if.arready;
    h1 = m1_if.arvalid && m1_if.arready;
    hr = s_if.rvalid && s_if.rready;
    hs = s_if.arvalid && s_if.arready;
    chk("arready_onehot", m0_if.arready & m1_if.arready, 0);
    chk("rvalid_onehot", m0_if.rvalid & m1_if.rvalid, 0);
    if (hs) begin
      if (ar_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ar_unexpected: got addr %0h, required no request", s_if.araddr);
      end else begin
        e = ar_q.pop_front();
        chk("ar_addr", s_if.araddr, e.addr);
        chk("ar_id", s_if.arid, e.id);
        chk("ar_len", s_if.arlen, e.len);
        chk("ar_size", s_if.arsize, 2'd2);
      end
    end
    if (m0_if.rvalid && m0_if.rready) check_r(1'b0, m0_if.rdata);
    if (m1_if.rvalid && m1_if.rready) check_r(1'b1, m1_if.rdata);
    if (hr && s_if.rlast) begin
      pop_seen   = 1'b1;
      ar0_at_pop = m0_if.arready;
    end
    @(posedge ACLK);
    #1;
    if (h0) mreq0.delete(0);
    if (h1) mreq1.delete(0);
    if (hr) sbeat_q.delete(0);
    drive();
    #2;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    mreq0.delete(); mreq1.delete(); ar_q.delete(); sbeat_q.delete(); r_q.delete();
    s_if.arready = 1'b0;
    drive();
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    #2;
  endtask

  task automatic wait_drain(input string nm, input int lim);
    int n;
    n = 0;
    while ((ar_q.size() != 0 || r_q.size() != 0) && n < lim) begin
      tick();
      n++;
    end
    checks++;
    if (ar_q.size() != 0 || r_q.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout with %0d AR and %0d R still pending, required 0", nm, ar_q.size(), r_q.size());
    end
  endtask

  task automatic add_req(input logic m, input logic [31:0] addr, input logic id, input logic [3:0] len);
    areq_t r;
    r = '{addr: addr, id: id, len: len};
    if (m) mreq1.push_back(r);
    else   mreq0.push_back(r);
  endtask

  task automatic add_ar(input logic [31:0] addr, input logic id, input logic [3:0] len);
    ar_q.push_back('{addr: addr, id: id, len: len});
  endtask

  task automatic add_beat(input logic mst, input logic [31:0] data, input logic id, input logic last);
    sbeat_q.push_back('{data: data, id: id, last: last});
    r_q.push_back('{mst: mst, data: data});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    gvec_t gtab[4];
    int n;
    gtab[0] = '{m0v: 1'b0, m1v: 1'b0, e0: 1'b0, e1: 1'b0};
    gtab[1] = '{m0v: 1'b1, m1v: 1'b0, e0: 1'b1, e1: 1'b0};
    gtab[2] = '{m0v: 1'b0, m1v: 1'b1, e0: 1'b0, e1: 1'b1};
    gtab[3] = '{m0v: 1'b1, m1v: 1'b1, e0: 1'b1, e1: 1'b0};

    m0_if.arsize = 2'd2; m0_if.arburst = 2'd1; m0_if.rready = 1'b1;
    m1_if.arsize = 2'd2; m1_if.arburst = 2'd1; m1_if.rready = 1'b1;
    m0_if.araddr = '0; m0_if.arid = '0; m0_if.arlen = '0;
    m1_if.araddr = '0; m1_if.arid = '0; m1_if.arlen = '0;
    s_if.rdata = '0; s_if.rid = '0; s_if.rlast = 1'b0; s_if.rresp = 2'd0;
    pop_seen = 1'b0; ar0_at_pop = 1'b0;
    do_reset();

    // Reset state
    chk("rst_arvalid", s_if.arvalid, 0);
    chk("rst_araddr", s_if.araddr, 0);
    chk("rst_arlen", s_if.arlen, 0);
    chk("rst_rid_err", rid_err, 0);
    s_if.rvalid = 1'b1;
    #1;
    chk("rst_stray_rready", s_if.rready, 0);
    chk("rst_stray_m0_rvalid", m0_if.rvalid, 0);
    chk("rst_stray_m1_rvalid", m1_if.rvalid, 0);
    s_if.rvalid = 1'b0;
    tick();

    // Grant table in IDLE with rr=0; requests withdrawn before any clock edge
    for (int i = 0; i < 4; i++) begin
      m0_if.arvalid = gtab[i].m0v;
      m1_if.arvalid = gtab[i].m1v;
      #1;
      chk($sformatf("grant_tab%0d_m0", i), m0_if.arready, gtab[i].e0);
      chk($sformatf("grant_tab%0d_m1", i), m1_if.arready, gtab[i].e1);
      m0_if.arvalid = 1'b0;
      m1_if.arvalid = 1'b0;
      tick();
    end

    // Single request, four-beat burst to M0
    s_if.arready = 1'b1;
    add_req(1'b0, 32'h100, 1'b0, 4'd3);
    add_ar(32'h100, 1'b0, 4'd3);
    drive();
    n = 0;
    while (mreq0.size() != 0 && n < 10) begin tick(); n++; end
    chk("single_granted", mreq0.size(), 0);
    chk("single_arvalid_next", s_if.arvalid, 1);
    chk("single_araddr", s_if.araddr, 32'h100);
    for (int k = 0; k < 4; k++) add_beat(1'b0, 32'hA0 + k, 1'b0, k == 3);
    wait_drain("single_drain", 30);
    s_if.rvalid = 1'b1;
    s_if.rlast  = 1'b0;
    #1;
    chk("single_empty_rready", s_if.rready, 0);
    chk("single_empty_m0_rvalid", m0_if.rvalid, 0);
    s_if.rvalid = 1'b0;

    // Contention from reset: M0, M1, M0, M1; R returns in grant order
    do_reset();
    s_if.arready = 1'b1;
    add_req(1'b0, 32'h200, 1'b0, 4'd0); add_req(1'b0, 32'h204, 1'b0, 4'd0);
    add_req(1'b1, 32'h300, 1'b1, 4'd0); add_req(1'b1, 32'h304, 1'b1, 4'd0);
    add_ar(32'h200, 1'b0, 4'd0); add_ar(32'h300, 1'b1, 4'd0);
    add_ar(32'h204, 1'b0, 4'd0); add_ar(32'h304, 1'b1, 4'd0);
    drive();
    wait_drain("contention_ar", 40);
    add_beat(1'b0, 32'hB0, 1'b0, 1'b1); add_beat(1'b1, 32'hB1, 1'b1, 1'b1);
    add_beat(1'b0, 32'hB2, 1'b0, 1'b1); add_beat(1'b1, 32'hB3, 1'b1, 1'b1);
    wait_drain("contention_r", 40);
    chk("contention_rid_err", rid_err, 0);

    // Slave AR backpressure for five cycles
    do_reset();
    add_req(1'b0, 32'h400, 1'b0, 4'd5); add_req(1'b1, 32'h500, 1'b1, 4'd2);
    add_ar(32'h400, 1'b0, 4'd5); add_ar(32'h500, 1'b1, 4'd2);
    drive();
    n = 0;
    while (!s_if.arvalid && n < 10) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_arvalid", s_if.arvalid, 1);
      chk("bp_araddr", s_if.araddr, 32'h400);
      chk("bp_arlen", s_if.arlen, 5);
      chk("bp_m0_arready", m0_if.arready, 0);
      chk("bp_m1_arready", m1_if.arready, 0);
      tick();
    end
    s_if.arready = 1'b1;
    wait_drain("bp_drain", 20);

    // Full FIFO: fifth request waits, granted one cycle after the first pop
    do_reset();
    s_if.arready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      add_req(1'b0, 32'h600 + 4 * k, 1'b0, 4'd0);
      add_ar(32'h600 + 4 * k, 1'b0, 4'd0);
    end
    drive();
    n = 0;
    while (ar_q.size() > 1 && n < 30) begin tick(); n++; end
    chk("full_four_grants", ar_q.size(), 1);
    for (int i = 0; i < 3; i++) begin
      chk("full_hold_arready", m0_if.arready, 0);
      chk("full_hold_arvalid", s_if.arvalid, 0);
      tick();
    end
    pop_seen = 1'b0;
    add_beat(1'b0, 32'hC0, 1'b0, 1'b1);
    n = 0;
    while (!pop_seen && n < 10) begin tick(); n++; end
    chk("full_pop_seen", pop_seen, 1);
    chk("full_blocked_at_pop", ar0_at_pop, 0);
    chk("full_grant_after_pop", m0_if.arready, 1);
    s_if.arready = 1'b0;
    tick();
    chk("full_fifth_sent", s_if.arvalid, 1);
    chk("full_fifth_addr", s_if.araddr, 32'h610);

    // Asynchronous reset mid-transaction clears everything
    ARESET = 1'b1;
    #1;
    chk("midrst_arvalid", s_if.arvalid, 0);
    chk("midrst_araddr", s_if.araddr, 0);
    s_if.rvalid = 1'b1;
    #1;
    chk("midrst_rready", s_if.rready, 0);
    chk("midrst_m0_rvalid", m0_if.rvalid, 0);
    do_reset();

    // R stall: M1 burst queued behind a stalled M0 burst; M0 beats carry a wrong RID
    chk("rid_err_after_reset", rid_err, 0);
    s_if.arready = 1'b1;
    add_req(1'b0, 32'h700, 1'b0, 4'd1); add_req(1'b1, 32'h800, 1'b1, 4'd1);
    add_ar(32'h700, 1'b0, 4'd1); add_ar(32'h800, 1'b1, 4'd1);
    drive();
    wait_drain("stall_ar", 20);
    m0_if.rready = 1'b0;
    add_beat(1'b0, 32'hD0, 1'b1, 1'b0); add_beat(1'b0, 32'hD1, 1'b1, 1'b1);
    add_beat(1'b1, 32'hE0, 1'b1, 1'b0); add_beat(1'b1, 32'hE1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rready", s_if.rready, 0);
      chk("stall_m0_rvalid", m0_if.rvalid, 1);
      chk("stall_m1_rvalid", m1_if.rvalid, 0);
    end
    m0_if.rready = 1'b1;
    tick();
    chk("rid_err_first_beat", rid_err, RID_CHK);
    wait_drain("stall_r", 20);
    chk("rid_err_sticky", rid_err, RID_CHK);
    do_reset();
    chk("rid_err_cleared", rid_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
